// File: rtl/ser_rx_hex.sv
// rtl/ser_rx_hex.sv - oversampling UART receiver that reassembles "x"+3-hex-char words into 12-bit data
module ser_rx_hex #(
  parameter int OVS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_os,
  input  logic        rx,
  output logic [11:0] data,
  output logic        valid,
  output logic        frm_err,
  output logic        chr_err,
  output logic        busy
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} frame_e;
  typedef enum logic [1:0] {W_SYNC, W_N2, W_N1, W_N0} word_e;

  logic          rx_meta_q, rx_s_q;
  frame_e        frame_q, frame_d;
  word_e         word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    w_q, w_d;
  logic [11:0]   data_q, data_d;
  logic          valid_q, valid_d, frm_err_q, frm_err_d, chr_err_q, chr_err_d;
  logic          char_done, is_nib, is_sync;
  logic [3:0]    nib;

  always_comb begin
    is_nib  = 1'b0;
    is_sync = (sh_q == 8'h78);
    nib     = sh_q[3:0];
    if (sh_q >= 8'h30 && sh_q <= 8'h39) begin
      is_nib = 1'b1;
    end else if ((sh_q >= 8'h41 && sh_q <= 8'h46) || (sh_q >= 8'h61 && sh_q <= 8'h66)) begin
      is_nib = 1'b1;
      nib    = sh_q[3:0] + 4'd9;
    end
  end

  always_comb begin
    frame_d   = frame_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    sh_d      = sh_q;
    w_d       = w_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    frm_err_d = 1'b0;
    chr_err_d = 1'b0;
    char_done = 1'b0;
    if (en_os) begin
      case (frame_q)
        IDLE: if (!rx_s_q) begin
          frame_d = START;
          cnt_d   = '0;
        end
        START: if (cnt_q == HALF_M1) begin
          if (!rx_s_q) begin
            frame_d = DATA;
            cnt_d   = '0;
            bidx_d  = 3'd0;
          end else begin
            frame_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        DATA: if (cnt_q == FULL_M1) begin
          sh_d[bidx_q] = rx_s_q;
          cnt_d        = '0;
          bidx_d       = bidx_q + 3'd1;
          if (bidx_q == 3'd7) frame_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        STOP: if (cnt_q == FULL_M1) begin
          frame_d   = IDLE;
          char_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        default: frame_d = IDLE;
      endcase
    end
    // Word assembly runs on the tick that samples the stop bit; its outputs land one cycle later.
    if (char_done) begin
      if (!rx_s_q) begin
        frm_err_d = 1'b1;
        word_d    = W_SYNC;
      end else if (is_sync) begin
        chr_err_d = (word_q != W_SYNC);
        word_d    = W_N2;
      end else if (!is_nib) begin
        chr_err_d = (word_q != W_SYNC);
        word_d    = W_SYNC;
      end else begin
        case (word_q)
          W_N2: begin
            w_d[7:4] = nib;
            word_d   = W_N1;
          end
          W_N1: begin
            w_d[3:0] = nib;
            word_d   = W_N0;
          end
          W_N0: begin
            data_d  = {w_q, nib};
            valid_d = 1'b1;
            word_d  = W_SYNC;
          end
          default: word_d = W_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      frame_q   <= IDLE;
      word_q    <= W_SYNC;
      cnt_q     <= '0;
      bidx_q    <= 3'd0;
      sh_q      <= 8'h00;
      w_q       <= 8'h00;
      data_q    <= 12'h000;
      valid_q   <= 1'b0;
      frm_err_q <= 1'b0;
      chr_err_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      frame_q   <= frame_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      bidx_q    <= bidx_d;
      sh_q      <= sh_d;
      w_q       <= w_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      frm_err_q <= frm_err_d;
      chr_err_q <= chr_err_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign frm_err = frm_err_q;
  assign chr_err = chr_err_q;
  assign busy    = (frame_q != IDLE);

endmodule
